rep5_tx_encoder: RTL and testbench
==================================

Name: rep5_tx_encoder

Overview:
Serial transmitter for the 5x repetition code whose receive end is the team's 5-input majority voter. It accepts a parallel data word over a valid/ready handshake and serialises it LSB first. Each data bit is held on the line for exactly REP consecutive clock cycles, so any REP received samples of one bit can be majority-voted back to the original bit. It sits between a word-level producer and the serial channel or link model.

Parameters:
DATA_W, 8, data word width in bits (>=1).
REP, 5, repetition factor: cycles per data bit. Must be odd and >=3. Default matches the 5-input voter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  encoder can accept a word this cycle.
in_data  input  DATA_W  word to transmit; sampled on the accept edge only.
tx_bit  output  1  serial coded bit.
tx_valid  output  1  tx_bit is meaningful this cycle.
tx_sof  output  1  first cycle of a frame (bit 0, repetition 0).
tx_eof  output  1  last cycle of a frame (bit DATA_W-1, repetition REP-1).
busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; shift register, rep_cnt and bit_cnt are cleared.
  - tx_bit, tx_valid, tx_sof, tx_eof and busy are all 0.
  - in_ready is forced to 0 while rst_n is low; it is gated with rst_n.
- States:
  - IDLE: in_ready=1, tx_valid=0.
  - SEND: tx_valid=1, busy=1.
- Accept: on a rising edge where in_valid and in_ready are both 1, latch in_data into the shift register, clear rep_cnt and bit_cnt, and enter SEND.
- Latency: if the word is accepted at edge k, tx_sof, tx_valid and tx_bit=in_data[0] are visible in the cycle after edge k.
- In SEND:
  - tx_bit = shreg[0], registered.
  - Each cycle rep_cnt increments. When rep_cnt wraps at REP-1 it returns to 0, shreg shifts right by one and bit_cnt increments.
  - tx_sof = (bit_cnt==0 && rep_cnt==0).
  - tx_eof = (bit_cnt==DATA_W-1 && rep_cnt==REP-1).
  - Frame length is exactly DATA_W*REP cycles of contiguous tx_valid.
- in_ready in SEND is 1 only in the tx_eof cycle, which allows back-to-back frames.
  - Accept during eof: the next frame's tx_sof follows immediately, with no tx_valid gap.
  - No accept during eof: return to IDLE, and tx_valid and busy drop the next cycle.
- in_valid while busy and not eof: the word is not accepted. The producer must hold in_data and in_valid stable until accepted.
- in_data is ignored in every cycle except the accept edge. Changing it mid-frame has no effect.
- Reset mid-frame aborts the frame immediately. After release, in IDLE, a new word restarts from tx_sof; no partial resume.
- Counter widths:
  - rep_cnt is $clog2(REP) bits.
  - bit_cnt is $clog2(DATA_W) bits, minimum 1.
  - Neither counter ever holds a value >= its modulus.
- Combinational outputs: only in_ready. All tx_* outputs and busy are registered.

Decomposition:
- Package rep_code_pkg holds:
  - REP_FACTOR=5 and DEFAULT_DATA_W=8.
  - State enum tx_state_t {IDLE, SEND}.
  - A compile-time check function that REP is odd and >=3.
- The receiver shares this package.
- One natural sub-module: mod_n_counter (parameter N). It has enable and clear inputs and value and wrap outputs, with asynchronous active-low reset. It is instantiated twice, for rep_cnt and bit_cnt (bit_cnt enabled by the rep_cnt wrap).

Test Plan:
- Reset, then in_data=8'hA5 with in_valid=1 for one cycle:
  - Accept occurs on the first edge.
  - tx_bit sequence is 1,0,1,0,0,1,0,1, each bit held for 5 cycles, 40 tx_valid cycles in total.
  - tx_sof is high in cycle 1 only; tx_eof is high in cycle 40 only; busy falls after cycle 40.
- Back-to-back: in_valid held high with 8'hFF then 8'h00:
  - in_ready is high only in the IDLE cycle and in the eof cycle.
  - tx_valid is high for 80 contiguous cycles: 40 ones, then 40 zeros.
  - tx_sof fires at cycles 1 and 41.
- Backpressure: 8'h3C is presented during 8'hFF's frame from cycle 10:
  - It is not accepted until the eof cycle, and in_ready is low for cycles 10-39.
  - Changing in_data to 8'hC3 at cycle 20 and holding it means 8'hC3 is transmitted.
- Reset mid-frame: assert rst_n=0 at cycle 17 of 8'h5A:
  - All outputs go to 0 without waiting for a clock.
  - After release, 8'h81 produces a clean 40-cycle frame starting with tx_sof and tx_bit=1.
- Round trip with the 5-input majority voter: random words, with up to 2 of each 5 repetitions flipped in the channel. The voter output over each 5-sample group equals the original bit for all 1000 words.
- Parameter sweep at DATA_W=1, REP=3: in_data=1'b1 gives 3 valid cycles with tx_sof and tx_eof high in cycles 1 and 3 respectively, and no counter overflow.

Source files
------------

// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-code transmitter and its majority-vote receiver.
package rep_code_pkg;

  // Repetition factor matching the 5-input majority voter on the receive side.
  localparam int REP_FACTOR     = 5;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // A majority vote needs an odd sample count and at least three samples.
  function automatic bit rep_is_valid(input int rep);
    return ((rep % 2) == 1) && (rep >= 3);
  endfunction

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rep5_tx_encoder_mod_n_counter.sv
// Modulo-N counter with synchronous clear and a combinational wrap flag.
module mod_n_counter
  import rep_code_pkg::*;
#(
  parameter int  N = 5,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_r;
  logic         at_max_s;

  // Terminal count detection; the counter never exceeds N-1.
  always_comb begin
    at_max_s = 1'b0;
    if (value_r == W'(N - 1)) begin
      at_max_s = 1'b1;
    end else begin
      at_max_s = 1'b0;
    end
  end

  // Count state: clear has priority, then advance with wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
    end else if (clr) begin
      value_r <= '0;
    end else if (en) begin
      if (at_max_s) begin
        value_r <= '0;
      end else begin
        value_r <= value_r + W'(1);
      end
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign wrap  = en & at_max_s;

endmodule

// File: rtl/rep5_tx_encoder.sv
// Repetition-code serial transmitter: each data bit is held for REP cycles, LSB first.
module rep5_tx_encoder
  import rep_code_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REP    = REP_FACTOR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic              busy
);

  localparam int REP_W = cnt_width(REP);
  localparam int BIT_W = cnt_width(DATA_W);

  generate
    if (!rep_is_valid(REP)) begin : g_bad_rep
      $error("rep5_tx_encoder: REP must be odd and >= 3");
    end
    if (DATA_W < 1) begin : g_bad_width
      $error("rep5_tx_encoder: DATA_W must be >= 1");
    end
  endgenerate

  tx_state_t         state_r;
  tx_state_t         state_nx_s;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] shreg_nx_s;
  logic              tx_bit_r;
  logic              tx_valid_r;
  logic              tx_sof_r;
  logic              tx_eof_r;
  logic              busy_r;
  logic              eof_nx_s;

  logic              in_ready_s;
  logic              accept_s;
  logic              sending_s;
  logic [REP_W-1:0]  rep_cnt_s;
  logic [BIT_W-1:0]  bit_cnt_s;
  logic              rep_wrap_s;
  logic              bit_wrap_s;
  logic              frame_end_s;

  // Ready only in IDLE or the final cycle of a frame, and never while reset is held.
  always_comb begin
    in_ready_s = 1'b0;
    sending_s  = 1'b0;
    if (state_r == SEND) begin
      sending_s = 1'b1;
    end else begin
      sending_s = 1'b0;
    end
    if (rst_n && ((state_r == IDLE) || tx_eof_r)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s    = in_valid & in_ready_s;
  assign frame_end_s = rep_wrap_s & bit_wrap_s;

  // Repetition index within the current bit.
  mod_n_counter #(.N(REP)) u_rep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sending_s),
    .clr   (accept_s),
    .value (rep_cnt_s),
    .wrap  (rep_wrap_s)
  );

  // Bit index within the frame, advanced once per completed repetition group.
  mod_n_counter #(.N(DATA_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rep_wrap_s),
    .clr   (accept_s),
    .value (bit_cnt_s),
    .wrap  (bit_wrap_s)
  );

  // Next-state, shift and look-ahead end-of-frame so the tx outputs can be registered.
  always_comb begin
    state_nx_s = state_r;
    shreg_nx_s = shreg_r;
    eof_nx_s   = 1'b0;
    if (accept_s) begin
      state_nx_s = SEND;
      shreg_nx_s = in_data;
      eof_nx_s   = 1'b0;
    end else if (state_r == SEND) begin
      if (frame_end_s) begin
        state_nx_s = IDLE;
      end else begin
        state_nx_s = SEND;
      end
      if (rep_wrap_s) begin
        shreg_nx_s = shreg_r >> 1'b1;
      end else begin
        shreg_nx_s = shreg_r;
      end
      if ((bit_cnt_s == BIT_W'(DATA_W - 1)) && (rep_cnt_s == REP_W'(REP - 2))) begin
        eof_nx_s = 1'b1;
      end else begin
        eof_nx_s = 1'b0;
      end
    end else begin
      state_nx_s = IDLE;
      shreg_nx_s = shreg_r;
      eof_nx_s   = 1'b0;
    end
  end

  // Transmit FSM with registered line outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      tx_bit_r   <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_sof_r   <= 1'b0;
      tx_eof_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      shreg_r  <= shreg_nx_s;
      tx_sof_r <= accept_s;
      tx_eof_r <= eof_nx_s;
      case (state_nx_s)
        SEND: begin
          tx_bit_r   <= shreg_nx_s[0];
          tx_valid_r <= 1'b1;
          busy_r     <= 1'b1;
        end
        IDLE: begin
          tx_bit_r   <= 1'b0;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
        default: begin
          tx_bit_r   <= 1'b0;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_s;
  assign tx_bit   = tx_bit_r;
  assign tx_valid = tx_valid_r;
  assign tx_sof   = tx_sof_r;
  assign tx_eof   = tx_eof_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_rep5_tx_encoder.sv
// Scoreboard testbench for rep5_tx_encoder (default 8x5 instance plus a 1x3 instance).
module tb_rep5_tx_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_sof;
  logic       tx_eof;
  logic       busy;

  logic       s_rst_n;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [0:0] s_in_data;
  logic       s_tx_bit;
  logic       s_tx_valid;
  logic       s_tx_sof;
  logic       s_tx_eof;
  logic       s_busy;

  int n_cmp;
  int n_bad;

  // expected per-cycle samples {bit, sof, eof} and expected words for the voter test
  logic [2:0] sbq[$];
  logic [7:0] wq[$];

  rep5_tx_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_sof   (tx_sof),
    .tx_eof   (tx_eof),
    .busy     (busy)
  );

  rep5_tx_encoder #(.DATA_W(1), .REP(3)) dut_small (
    .clk      (clk),
    .rst_n    (s_rst_n),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .tx_bit   (s_tx_bit),
    .tx_valid (s_tx_valid),
    .tx_sof   (s_tx_sof),
    .tx_eof   (s_tx_eof),
    .busy     (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line samples of one 8x5 frame.
  task automatic push_frame(input logic [7:0] d);
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < 5; r++) begin
        sbq.push_back({d[b], (b == 0 && r == 0) ? 1'b1 : 1'b0, (b == 7 && r == 4) ? 1'b1 : 1'b0});
      end
    end
  endtask

  // Channel error pattern: at most two of five repetitions flipped.
  function automatic logic [4:0] gen_mask();
    logic [4:0] m;
    int k;
    int p1;
    int p2;
    m  = 5'b00000;
    k  = $urandom_range(0, 2);
    p1 = $urandom_range(0, 4);
    p2 = (p1 + $urandom_range(1, 4)) % 5;
    if (k >= 1) m[p1] = 1'b1;
    if (k == 2) m[p2] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_bit, tx_valid, tx_sof, tx_eof, busy, in_ready} !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_outputs got %b required 000000", {tx_bit, tx_valid, tx_sof, tx_eof, busy, in_ready});
    end
    rst_n = 1'b1; s_rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, tx_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release_idle got rdy/val/busy=%b required 100", {in_ready, tx_valid, busy});
    end
  endtask

  task automatic test_single();
    int nvalid;
    logic [2:0] e3;
    logic exp_on;
    logic exp_rdy;
    nvalid = 0;
    in_valid = 1'b1; in_data = 8'hA5;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_idle_ready got %b required 1", in_ready);
    end
    push_frame(8'hA5);
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin
        nvalid++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL single_extra_valid cycle %0d got valid required idle", c);
        end else begin
          e3 = sbq.pop_front();
          if ({tx_bit, tx_sof, tx_eof} !== e3) begin
            n_bad++; $display("FAIL single_stream cycle %0d got bit/sof/eof=%b required %b", c, {tx_bit, tx_sof, tx_eof}, e3);
          end
        end
      end
      exp_on  = (c <= 40);
      exp_rdy = !(c >= 1 && c <= 39);
      n_cmp++;
      if ({tx_valid, busy, in_ready} !== {exp_on, exp_on, exp_rdy}) begin
        n_bad++; $display("FAIL single_ctrl cycle %0d got val/busy/rdy=%b required %b", c, {tx_valid, busy, in_ready}, {exp_on, exp_on, exp_rdy});
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    n_cmp++;
    if (nvalid != 40 || sbq.size() != 0) begin
      n_bad++; $display("FAIL single_length got %0d valid cycles (%0d left) required 40 (0)", nvalid, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_back_to_back();
    logic [2:0] e3;
    logic exp_on;
    logic exp_rdy;
    in_valid = 1'b1; in_data = 8'hFF;
    push_frame(8'hFF);
    for (int c = 1; c <= 82; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra_valid cycle %0d got valid required idle", c);
        end else begin
          e3 = sbq.pop_front();
          if ({tx_bit, tx_sof, tx_eof} !== e3) begin
            n_bad++; $display("FAIL b2b_stream cycle %0d got bit/sof/eof=%b required %b", c, {tx_bit, tx_sof, tx_eof}, e3);
          end
        end
      end
      exp_on  = (c >= 1 && c <= 80);
      exp_rdy = (c == 40 || c >= 80);
      n_cmp++;
      if ({tx_valid, in_ready} !== {exp_on, exp_rdy}) begin
        n_bad++; $display("FAIL b2b_ctrl cycle %0d got val/rdy=%b required %b", c, {tx_valid, in_ready}, {exp_on, exp_rdy});
      end
      if (c < 40) begin
        in_valid = 1'b1; in_data = 8'h00;
      end else if (c == 40) begin
        in_valid = 1'b1; in_data = 8'h00;
        push_frame(8'h00);
      end else begin
        in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL b2b_leftover got %0d samples pending required 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_backpressure();
    logic [2:0] e3;
    logic exp_on;
    logic exp_rdy;
    in_valid = 1'b1; in_data = 8'hFF;
    push_frame(8'hFF);
    for (int c = 1; c <= 82; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_valid cycle %0d got valid required idle", c);
        end else begin
          e3 = sbq.pop_front();
          if ({tx_bit, tx_sof, tx_eof} !== e3) begin
            n_bad++; $display("FAIL bp_stream cycle %0d got bit/sof/eof=%b required %b", c, {tx_bit, tx_sof, tx_eof}, e3);
          end
        end
      end
      exp_on  = (c >= 1 && c <= 80);
      exp_rdy = (c == 40 || c >= 80);
      n_cmp++;
      if ({tx_valid, in_ready} !== {exp_on, exp_rdy}) begin
        n_bad++; $display("FAIL bp_ctrl cycle %0d got val/rdy=%b required %b", c, {tx_valid, in_ready}, {exp_on, exp_rdy});
      end
      if (c < 10) begin
        in_valid = 1'b0; in_data = 8'($urandom);
      end else if (c < 20) begin
        in_valid = 1'b1; in_data = 8'h3C;
      end else if (c <= 40) begin
        in_valid = 1'b1; in_data = 8'hC3;
        if (c == 40) push_frame(8'hC3);
      end else begin
        in_valid = 1'b0; in_data = 8'($urandom);
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL bp_leftover got %0d samples pending required 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset_midframe();
    logic [2:0] e3;
    int nvalid;
    in_valid = 1'b1; in_data = 8'h5A;
    push_frame(8'h5A);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (tx_valid === 1'b1) begin
        n_cmp++;
        e3 = (sbq.size() != 0) ? sbq.pop_front() : 3'bxxx;
        if ({tx_bit, tx_sof, tx_eof} !== e3) begin
          n_bad++; $display("FAIL mid_stream cycle %0d got bit/sof/eof=%b required %b", c, {tx_bit, tx_sof, tx_eof}, e3);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_bit, tx_valid, tx_sof, tx_eof, busy, in_ready} !== 6'b000000) begin
      n_bad++; $display("FAIL mid_async_reset got %b required 000000", {tx_bit, tx_valid, tx_sof, tx_eof, busy, in_ready});
    end
    sbq.delete();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_valid, busy, in_ready} !== 3'b000) begin
      n_bad++; $display("FAIL mid_reset_hold got val/busy/rdy=%b required 000", {tx_valid, busy, in_ready});
    end
    rst_n = 1'b1;
    #1;
    in_valid = 1'b1; in_data = 8'h81;
    push_frame(8'h81);
    nvalid = 0;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (tx_valid === 1'b1) begin
        nvalid++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL mid_restart_extra cycle %0d got valid required idle", c);
        end else begin
          e3 = sbq.pop_front();
          if ({tx_bit, tx_sof, tx_eof} !== e3) begin
            n_bad++; $display("FAIL mid_restart_stream cycle %0d got bit/sof/eof=%b required %b", c, {tx_bit, tx_sof, tx_eof}, e3);
          end
        end
      end
    end
    n_cmp++;
    if (nvalid != 40 || sbq.size() != 0) begin
      n_bad++; $display("FAIL mid_restart_length got %0d valid (%0d left) required 40 (0)", nvalid, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_roundtrip();
    logic [4:0] mask;
    logic [7:0] dec;
    logic [7:0] ew;
    int ridx;
    int bidx;
    int ones;
    int words_done;
    int gaps;
    logic fb;
    mask = gen_mask(); dec = 8'h00; ridx = 0; bidx = 0; ones = 0; words_done = 0; gaps = 0;
    for (int c = 0; c <= 40002; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if ((c <= 40000) && (tx_valid !== 1'b1)) gaps++;
        if (tx_valid === 1'b1) begin
          if (tx_sof === 1'b1) begin
            ridx = 0; bidx = 0; ones = 0; dec = 8'h00;
          end
          fb = tx_bit ^ mask[ridx];
          ones += int'(fb);
          ridx++;
          if (ridx == 5) begin
            if (bidx < 8) dec[bidx] = (ones >= 3);
            bidx++; ridx = 0; ones = 0;
            mask = gen_mask();
          end
          if (tx_eof === 1'b1) begin
            ew = (wq.size() != 0) ? wq.pop_front() : 8'hxx;
            words_done++;
            n_cmp++;
            if (dec !== ew) begin
              n_bad++; $display("FAIL roundtrip_word %0d got %h required %h", words_done, dec, ew);
            end
          end
        end
      end
      if (c < 40000 && (c % 40) == 0) begin
        ew = 8'($urandom);
        in_valid = 1'b1; in_data = ew;
        wq.push_back(ew);
      end else if (c >= 40000) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
      end
    end
    n_cmp++;
    if (words_done != 1000 || gaps != 0) begin
      n_bad++; $display("FAIL roundtrip_count got %0d words %0d gaps required 1000 words 0 gaps", words_done, gaps);
    end
    wq.delete();
  endtask

  task automatic test_small_param();
    logic [5:0] exp6;
    s_in_valid = 1'b1; s_in_data = 1'b1;
    n_cmp++;
    if (s_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL small_idle_ready got %b required 1", s_in_ready);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      s_in_valid = 1'b0; s_in_data = 1'b0;
      exp6 = {(c <= 3) ? 1'b1 : 1'b0, (c == 1) ? 1'b1 : 1'b0, (c == 3) ? 1'b1 : 1'b0,
              (c <= 3) ? 1'b1 : 1'b0, (c <= 3) ? 1'b1 : 1'b0, (c >= 3) ? 1'b1 : 1'b0};
      n_cmp++;
      if ({s_tx_valid, s_tx_sof, s_tx_eof, s_tx_bit, s_busy, s_in_ready} !== exp6) begin
        n_bad++; $display("FAIL small_frame cycle %0d got val/sof/eof/bit/busy/rdy=%b required %b",
                          c, {s_tx_valid, s_tx_sof, s_tx_eof, s_tx_bit, s_busy, s_in_ready}, exp6);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    test_small_param();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
